// File: rtl/oc8051_xrom_fetch.sv
`default_nettype none
// oc8051_xrom_fetch: three-byte external program-memory fetch with a one-entry buffer.
// Rev 1.0 - initial release.
module oc8051_xrom_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_inval,
  output logic        o_ack,
  output logic [7:0]  o_data1,
  output logic [7:0]  o_data2,
  output logic [7:0]  o_data3,
  output logic [15:0] o_xaddr,
  output logic        o_xstb,
  input  logic        i_xack,
  input  logic [7:0]  i_xdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_base;
  logic [15:0] r_tag;
  logic        r_valid;
  logic        r_inval_seen;
  logic [7:0]  r_stage0;
  logic [7:0]  r_stage1;
  logic [7:0]  r_data1;
  logic [7:0]  r_data2;
  logic [7:0]  r_data3;
  logic [15:0] r_xaddr;
  logic        r_xstb;
  logic        r_ack;

  logic        w_start;
  logic        w_tag_hit;
  logic        w_hit;
  logic        w_miss;
  logic        w_rd;

  // A request is only considered in IDLE and never during its own ack cycle.
  assign w_start   = (r_state == S_IDLE) && i_req && !r_ack;
  assign w_tag_hit = r_valid && (i_addr == r_tag) && !i_inval;
  assign w_hit     = w_start && w_tag_hit;
  assign w_miss    = w_start && !w_tag_hit;
  assign w_rd      = (r_state == S_RD0) || (r_state == S_RD1) || (r_state == S_RD2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_miss) w_next = S_RD0;
      S_RD0:   if (i_xack) w_next = S_RD1;
      S_RD1:   if (i_xack) w_next = S_RD2;
      S_RD2:   if (i_xack) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base       <= 16'h0000;
      r_tag        <= 16'h0000;
      r_valid      <= 1'b0;
      r_inval_seen <= 1'b0;
      r_stage0     <= 8'h00;
      r_stage1     <= 8'h00;
      r_data1      <= 8'h00;
      r_data2      <= 8'h00;
      r_data3      <= 8'h00;
      r_xaddr      <= 16'h0000;
      r_xstb       <= 1'b0;
      r_ack        <= 1'b0;
    end else begin
      r_ack <= w_hit || ((r_state == S_RD2) && i_xack);

      if (w_miss) begin
        r_base       <= i_addr;
        r_xaddr      <= i_addr;
        r_xstb       <= 1'b1;
        r_inval_seen <= 1'b0;
      end else if (w_rd && i_inval) begin
        r_inval_seen <= 1'b1;
      end

      case (r_state)
        S_RD0: begin
          if (i_xack) begin
            r_stage0 <= i_xdata;
            r_xaddr  <= r_base + 16'd1;
          end
        end
        S_RD1: begin
          if (i_xack) begin
            r_stage1 <= i_xdata;
            r_xaddr  <= r_base + 16'd2;
          end
        end
        S_RD2: begin
          if (i_xack) begin
            r_xstb  <= 1'b0;
            r_data1 <= r_stage0;
            r_data2 <= r_stage1;
            r_data3 <= i_xdata;
          end
        end
        S_DONE: begin
          r_tag <= r_base;
        end
        default: begin
        end
      endcase

      // An invalidate seen while the bytes were in flight keeps the new entry invalid.
      if (i_inval) begin
        r_valid <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_valid <= !r_inval_seen;
      end
    end
  end

  assign o_ack   = r_ack;
  assign o_data1 = r_data1;
  assign o_data2 = r_data2;
  assign o_data3 = r_data3;
  assign o_xaddr = r_xaddr;
  assign o_xstb  = r_xstb;

endmodule
`default_nettype wire

// File: tb/tb_oc8051_xrom_fetch.sv
`default_nettype none
// tb_oc8051_xrom_fetch: directed scoreboard bench for the external fetch unit.
// Rev 1.0 - initial release.
module tb_oc8051_xrom_fetch;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_inval;
  logic        o_ack;
  logic [7:0]  o_data1;
  logic [7:0]  o_data2;
  logic [7:0]  o_data3;
  logic [15:0] o_xaddr;
  logic        o_xstb;
  logic        i_xack;
  logic [7:0]  i_xdata;

  int n_checks = 0;
  int n_pass   = 0;
  int wait_cfg = 0;
  int wcnt     = 0;
  int xstb_cycles = 0;

  logic [23:0] dq[$];
  logic [15:0] xq[$];
  logic [23:0] exp_d;

  oc8051_xrom_fetch dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_inval (i_inval),
    .o_ack   (o_ack),
    .o_data1 (o_data1),
    .o_data2 (o_data2),
    .o_data3 (o_data3),
    .o_xaddr (o_xaddr),
    .o_xstb  (o_xstb),
    .i_xack  (i_xack),
    .i_xdata (i_xdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // External memory: xack after wait_cfg wait cycles per byte; xdata is junk while xack is low.
  initial begin
    i_xack  = 1'b0;
    i_xdata = 8'hA5;
    forever begin
      @(negedge clk);
      if (o_xstb) begin
        xstb_cycles++;
        if (wcnt < wait_cfg) begin
          i_xack  = 1'b0;
          i_xdata = 8'hA5;
          wcnt++;
        end else begin
          i_xack  = 1'b1;
          i_xdata = mem(o_xaddr);
          wcnt    = 0;
        end
        chk("xstb_expected", 32'(xq.size() > 0), 32'd1);
        if (xq.size() > 0) begin
          chk("xaddr", {16'h0, o_xaddr}, {16'h0, xq[0]});
          if (i_xack) void'(xq.pop_front());
        end
      end else begin
        i_xack  = 1'b0;
        i_xdata = 8'hA5;
        wcnt    = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (o_ack) begin
        chk("ack_expected", 32'(dq.size() > 0), 32'd1);
        if (dq.size() > 0) begin
          exp_d = dq.pop_front();
          chk("data1", {24'h0, o_data1}, {24'h0, exp_d[23:16]});
          chk("data2", {24'h0, o_data2}, {24'h0, exp_d[15:8]});
          chk("data3", {24'h0, o_data3}, {24'h0, exp_d[7:0]});
        end
      end
    end
  end

  // inval_at: negedge index (0 = together with req) at which inval pulses; -1 for none.
  task automatic do_fetch(input logic [15:0] a, input bit miss, input int inval_at);
    int          cnt;
    bit          got;
    int          exp_lat;
    int          exp_x;
    logic [23:0] snap;
    exp_lat = miss ? (4 + 3 * wait_cfg) : 1;
    exp_x   = miss ? (3 * (1 + wait_cfg)) : 0;
    @(negedge clk);
    snap = {o_data1, o_data2, o_data3};
    dq.push_back({mem(a), mem(a + 16'd1), mem(a + 16'd2)});
    if (miss) begin
      xq.push_back(a);
      xq.push_back(a + 16'd1);
      xq.push_back(a + 16'd2);
    end
    xstb_cycles = 0;
    i_addr  = a;
    i_req   = 1'b1;
    i_inval = (inval_at == 0);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (i_inval) i_inval = 1'b0;
      if (cnt == inval_at) i_inval = 1'b1;
      if (o_ack) got = 1'b1;
      else chk("data_stable", {8'h0, o_data1, o_data2, o_data3}, {8'h0, snap});
    end
    i_req   = 1'b0;
    i_inval = 1'b0;
    chk("ack_latency", cnt, exp_lat);
    chk("xstb_cycles", xstb_cycles, exp_x);
  endtask

  initial begin
    rst     = 1'b1;
    i_req   = 1'b0;
    i_addr  = 16'h0000;
    i_inval = 1'b0;
    #1;
    chk("rst_ack",   {31'h0, o_ack},  32'h0);
    chk("rst_xstb",  {31'h0, o_xstb}, 32'h0);
    chk("rst_xaddr", {16'h0, o_xaddr}, 32'h0);
    chk("rst_data",  {8'h0, o_data1, o_data2, o_data3}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_fetch(16'h8010, 1'b1, -1);
    do_fetch(16'h8010, 1'b0, -1);
    do_fetch(16'h8011, 1'b1, -1);

    wait_cfg = 2;
    do_fetch(16'h9000, 1'b1, -1);
    wait_cfg = 0;

    do_fetch(16'hFFFE, 1'b1, -1);

    do_fetch(16'h8020, 1'b1, 2);
    do_fetch(16'h8020, 1'b1, -1);
    do_fetch(16'h8020, 1'b0, -1);
    do_fetch(16'h8020, 1'b1, 0);

    do_fetch(16'h8010, 1'b1, -1);
    @(negedge clk);
    xq.push_back(16'h8030);
    xq.push_back(16'h8031);
    i_addr = 16'h8030;
    i_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rd1_xaddr", {16'h0, o_xaddr}, 32'h8031);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_xstb",  {31'h0, o_xstb}, 32'h0);
    chk("midrst_ack",   {31'h0, o_ack},  32'h0);
    chk("midrst_xaddr", {16'h0, o_xaddr}, 32'h0);
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_xq", xq.size(), 0);
    do_fetch(16'h8010, 1'b1, -1);

    repeat (3) @(negedge clk);
    chk("dq_drained", dq.size(), 0);
    chk("xq_drained", xq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
